// File: rtl/bidirect_deser_if.sv
// rtl/bidirect_deser_if.sv - serial input and word output bundle for bidirect_deser
interface bidirect_deser_if #(
  parameter int W = 4
);
  logic         en;
  logic         sin;
  logic         left;
  logic         right;
  logic         clr;
  logic [W-1:0] q;
  logic         q_valid;
  logic         q_ready;
  logic         busy;
  logic         dir;
  logic         ovf;

  modport master (
    output en, sin, left, right, clr, q_ready,
    input  q, q_valid, busy, dir, ovf
  );

  modport slave (
    input  en, sin, left, right, clr, q_ready,
    output q, q_valid, busy, dir, ovf
  );
endinterface

// File: rtl/bidirect_deser.sv
// rtl/bidirect_deser.sv - serial-to-parallel receiver with direction latch and one-word skid
module bidirect_deser #(
  parameter int W = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  bidirect_deser_if.slave  bus
);
  localparam int CW = $clog2(W + 1);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_HOLD} state_t;

  state_t         r_state;
  state_t         w_next;
  logic [W-1:0]   r_sr;
  logic [W-1:0]   r_q;
  logic [CW-1:0]  r_cnt;
  logic           r_q_valid;
  logic           r_dir;
  logic           r_ovf;

  logic           w_legal;
  logic           w_drain;
  logic           w_last;
  logic           w_out_free;
  logic           w_take_bit;
  logic           w_load_shift;
  logic           w_load_hold;
  logic           w_drop;
  logic           w_shift_dir;
  logic [W-1:0]   w_sr_next;

  assign w_legal    = bus.left ^ bus.right;
  assign w_drain    = r_q_valid & bus.q_ready;
  assign w_last     = (r_cnt == CW'(W - 1));
  assign w_out_free = ~r_q_valid | bus.q_ready;
  assign w_sr_next  = w_shift_dir ? {bus.sin, r_sr[W-1:1]} : {r_sr[W-2:0], bus.sin};

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    if (bus.clr) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (bus.en && w_legal) w_next = S_SHIFT;
        S_SHIFT: if (bus.en && w_last) w_next = w_out_free ? S_IDLE : S_HOLD;
        S_HOLD:  if (w_drain) w_next = S_IDLE;
        default: w_next = S_IDLE;
      endcase
    end
  end

  // Direction comes from the inputs only on the first bit; mid-frame it is the latched one.
  always_comb begin
    w_take_bit   = 1'b0;
    w_load_shift = 1'b0;
    w_load_hold  = 1'b0;
    w_drop       = 1'b0;
    w_shift_dir  = r_dir;
    if (!bus.clr) begin
      case (r_state)
        S_IDLE: begin
          if (bus.en && w_legal) begin
            w_take_bit  = 1'b1;
            w_shift_dir = bus.right;
          end
        end
        S_SHIFT: begin
          if (bus.en) begin
            w_take_bit   = 1'b1;
            w_load_shift = w_last & w_out_free;
          end
        end
        S_HOLD: begin
          w_drop      = bus.en;
          w_load_hold = w_drain;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_sr      <= '0;
      r_cnt     <= '0;
      r_q       <= '0;
      r_q_valid <= 1'b0;
      r_dir     <= 1'b0;
      r_ovf     <= 1'b0;
    end else begin
      if (bus.clr) begin
        r_sr  <= '0;
        r_cnt <= '0;
        r_ovf <= 1'b0;
      end else begin
        if (w_load_shift || w_load_hold) begin
          r_sr  <= '0;
          r_cnt <= '0;
        end else if (w_take_bit) begin
          r_sr  <= w_sr_next;
          r_cnt <= r_cnt + CW'(1);
        end
        if (w_drop) r_ovf <= 1'b1;
      end

      if (r_state == S_IDLE && w_take_bit) r_dir <= bus.right;

      if (w_load_shift)     r_q <= w_sr_next;
      else if (w_load_hold) r_q <= r_sr;

      if (w_load_shift || w_load_hold) r_q_valid <= 1'b1;
      else if (w_drain)                r_q_valid <= 1'b0;
    end
  end

  assign bus.q       = r_q;
  assign bus.q_valid = r_q_valid;
  assign bus.busy    = (r_state != S_IDLE);
  assign bus.dir     = r_dir;
  assign bus.ovf     = r_ovf;
endmodule
